// File: rtl/aes_subbytes_seq_if.sv
// Handshake and sbox-stage bundle for aes_subbytes_seq.
// The slave modport is the block's view; the master modport is the environment's view.
interface aes_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [7:0]   sbox_x;
  logic         sbox_xv;
  logic [7:0]   sbox_y;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_state, sbox_y, out_ready,
    output in_ready, sbox_x, sbox_xv, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, sbox_y, out_ready,
    input  in_ready, sbox_x, sbox_xv, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: streams 16 state bytes through an external sbox with latency SBOX_LAT.
// Define AES_SUBBYTES_SHIFTROWS_EN to fold ShiftRows into the result byte placement.
module aes_subbytes_seq #(
  parameter int SBOX_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  aes_subbytes_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] res_q, res_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   x_q, x_d;
  logic         xv_q, xv_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [4:0]   tag_q [SBOX_LAT];
  logic [4:0]   tag_d [SBOX_LAT];
  logic         cap_last_s;

  function automatic logic [7:0] get_byte(input logic [127:0] st, input logic [3:0] k);
    get_byte = st[{~k, 3'b000} +: 8];
  endfunction

  // Output slot for the result of input byte k (column shifted left by its row when enabled).
  function automatic logic [3:0] dest_slot(input logic [3:0] k);
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    dest_slot = {k[3:2] - k[1:0], k[1:0]};
`else
    dest_slot = k;
`endif
  endfunction

  assign cap_last_s = (tag_q[SBOX_LAT-1] == {1'b1, 4'd15});

  // Next-state, issue and capture logic.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    res_d       = res_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    x_d         = 8'h00;
    xv_d        = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    tag_d[0]    = {xv_q, cnt_q};
    for (int i = 1; i < SBOX_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (tag_q[SBOX_LAT-1][4]) begin
      res_d[{~dest_slot(tag_q[SBOX_LAT-1][3:0]), 3'b000} +: 8] = bus.sbox_y;
    end else begin
      res_d = res_q;
    end
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          state_d    = ISSUE;
          data_d     = bus.in_state;
          cnt_d      = 4'd0;
          x_d        = get_byte(bus.in_state, 4'd0);
          xv_d       = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd15) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
          x_d   = get_byte(data_q, cnt_q + 4'd1);
          xv_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (cap_last_s) begin
          state_d     = DONE;
          out_d       = res_d;
          out_valid_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any operation and clears the tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_q      <= 128'd0;
      res_q       <= 128'd0;
      out_q       <= 128'd0;
      cnt_q       <= 4'd0;
      x_q         <= 8'h00;
      xv_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        tag_q[i] <= 5'd0;
      end
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      res_q       <= res_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      xv_q        <= xv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < SBOX_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sbox_x    = x_q;
  assign bus.sbox_xv   = xv_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_q;
  assign bus.busy      = busy_q;

endmodule
